// File: rtl/line_rotation_key_scheduler.sv
// Per-line cut-position sequencer for line_rotator: prefetches keystream bytes into a small FIFO
// and hands one to each active line on the H rising edge; reseeds the keystream once per field.
module line_rotation_key_scheduler #(
    parameter int unsigned PREFETCH_DEPTH  = 4,
    parameter int unsigned DEFAULT_CUT     = 0,
    parameter int unsigned LINE_COUNT_BITS = 10
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic                       V,
    input  logic                       H,
    input  logic [7:0]                 key_data,
    input  logic                       key_valid,
    output logic                       key_ready,
    output logic                       seed_load,
    output logic [7:0]                 raw_cut_position,
    output logic                       cut_valid,
    output logic [LINE_COUNT_BITS-1:0] line_count,
    output logic                       underrun
);

    localparam int unsigned AW = $clog2(PREFETCH_DEPTH);
    localparam logic [7:0] DefaultCut = 8'(DEFAULT_CUT);
    localparam logic [AW:0] FifoFull = (AW + 1)'(PREFETCH_DEPTH);

    typedef enum logic [1:0] {StIdle, StBlank, StActive} state_e;

    state_e state_q, state_d;

    logic prev_h_q, prev_v_q;
    logic h_rise, v_rise, v_fall;

    logic [7:0]                 raw_q, raw_d;
    logic                       cut_valid_q, cut_valid_d;
    logic [LINE_COUNT_BITS-1:0] line_count_q, line_count_d;
    logic                       underrun_q, underrun_d;

    logic [7:0]    fifo_mem [PREFETCH_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   fifo_cnt_q;
    logic          fifo_full, fifo_empty;
    logic          push, pop, flush;

    // Edges are masked during reset so stale history cannot leak into the comb outputs.
    assign h_rise = !reset && !prev_h_q && H;
    assign v_rise = !reset && !prev_v_q && V;
    assign v_fall = !reset && prev_v_q && !V;

    assign fifo_full  = (fifo_cnt_q == FifoFull);
    assign fifo_empty = (fifo_cnt_q == '0);
    assign push       = key_valid && key_ready;

    always_comb begin
        state_d      = state_q;
        seed_load    = 1'b0;
        key_ready    = 1'b0;
        flush        = 1'b0;
        pop          = 1'b0;
        raw_d        = raw_q;
        cut_valid_d  = cut_valid_q;
        line_count_d = line_count_q;
        underrun_d   = underrun_q;

        unique case (state_q)
            StIdle: begin
                if (v_rise && enable) begin
                    state_d   = StBlank;
                    seed_load = 1'b1;
                    flush     = 1'b1;
                end
            end
            StBlank, StActive: begin
                key_ready = !fifo_full;
                if (v_rise) begin
                    // The reseed/flush cycle never accepts a key, even if one is offered.
                    key_ready   = 1'b0;
                    flush       = 1'b1;
                    raw_d       = DefaultCut;
                    cut_valid_d = 1'b0;
                    if (enable) begin
                        state_d   = StBlank;
                        seed_load = 1'b1;
                    end else begin
                        state_d      = StIdle;
                        line_count_d = '0;
                    end
                end else if (state_q == StBlank) begin
                    if (v_fall) begin
                        state_d      = StActive;
                        line_count_d = '0;
                    end
                end else if (h_rise) begin
                    if (!fifo_empty) begin
                        pop         = 1'b1;
                        raw_d       = fifo_mem[rd_ptr_q];
                        cut_valid_d = 1'b1;
                    end else begin
                        raw_d       = DefaultCut;
                        cut_valid_d = 1'b0;
                        underrun_d  = 1'b1;
                    end
                    line_count_d = (&line_count_q) ? line_count_q : line_count_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (reset) begin
            key_ready = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        prev_h_q <= H;
        prev_v_q <= V;
        if (reset) begin
            state_q      <= StIdle;
            raw_q        <= DefaultCut;
            cut_valid_q  <= 1'b0;
            line_count_q <= '0;
            underrun_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            raw_q        <= raw_d;
            cut_valid_q  <= cut_valid_d;
            line_count_q <= line_count_d;
            underrun_q   <= underrun_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                fifo_cnt_q <= fifo_cnt_q + 1'b1;
            end else if (!push && pop) begin
                fifo_cnt_q <= fifo_cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= key_data;
        end
    end

    assign raw_cut_position = raw_q;
    assign cut_valid        = cut_valid_q;
    assign line_count       = line_count_q;
    assign underrun         = underrun_q;

endmodule
